// File: rtl/muldiv_if.sv
// muldiv_if: request, HI/LO write and result signals of the multiply/divide unit.
interface muldiv_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        hi_write;
   logic        lo_write;
   logic [31:0] write_data;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   modport master (
      output start, op, operand_a, operand_b, hi_write, lo_write, write_data,
      input  busy, done, hi, lo
   );
   modport slave (
      input  start, op, operand_a, operand_b, hi_write, lo_write, write_data,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers, 33-cycle latency.
module muldiv_unit (
   input logic     clock,
   input logic     reset,
   muldiv_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t      state_q;
   logic [1:0]  op_q;
   logic        sa_q, sb_q, bz_q, busy_q, done_q;
   logic [31:0] acc_q, sh_q, b_q, hi_q, lo_q;
   logic [4:0]  cnt_q;
   logic        is_div, is_sgn, in_sgn;
   logic [32:0] mul_s, div_r, div_t;
   logic [31:0] acc_d, sh_d, hi_d, lo_d, q_f, r_f, mag_a, mag_b;
   logic [63:0] prod, prod_f;
   assign is_div = op_q[1];
   assign is_sgn = ~op_q[0];
   assign in_sgn = ~bus.op[0];
   assign mag_a  = in_sgn && bus.operand_a[31] ? -bus.operand_a : bus.operand_a;
   assign mag_b  = in_sgn && bus.operand_b[31] ? -bus.operand_b : bus.operand_b;
   // acc holds the product high half (multiply) or partial remainder (divide);
   // sh holds the multiplier/product low half or dividend/quotient bits.
   assign mul_s  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : 33'd0);
   assign div_r  = {acc_q, sh_q[31]};
   assign div_t  = div_r - {1'b0, b_q};
   assign acc_d  = is_div ? (div_t[32] ? div_r[31:0] : div_t[31:0]) : mul_s[32:1];
   assign sh_d   = is_div ? {sh_q[30:0], ~div_t[32]} : {mul_s[0], sh_q[31:1]};
   assign prod   = {acc_q, sh_q};
   assign prod_f = is_sgn && (sa_q ^ sb_q) ? -prod : prod;
   assign q_f    = bz_q ? '1 : (is_sgn && (sa_q ^ sb_q) ? -sh_q : sh_q);
   assign r_f    = is_sgn && sa_q ? -acc_q : acc_q;
   assign hi_d   = is_div ? r_f : prod_f[63:32];
   assign lo_d   = is_div ? q_f : prod_f[31:0];
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  op_q    <= bus.op;
                  sa_q    <= bus.operand_a[31];
                  sb_q    <= bus.operand_b[31];
                  bz_q    <= bus.operand_b == '0;
                  acc_q   <= '0;
                  sh_q    <= mag_a;
                  b_q     <= mag_b;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
               end else begin
                  if (bus.hi_write) hi_q <= bus.write_data;
                  if (bus.lo_write) lo_q <= bus.write_data;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               sh_q  <= sh_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= FIX;
            end
            FIX: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand-written control sequences for muldiv_unit.
module tb_muldiv_unit;
   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
   } vec_t;
   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
   logic clock = 1'b0;
   logic reset;
   int   n_vec = 0, n_bad = 0;
   vec_t vt[13];
   muldiv_if bus();
   muldiv_unit dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
      @(posedge clock); #1;
      bus.start = 1'b0; bus.op = 2'($urandom); bus.operand_a = $urandom; bus.operand_b = $urandom;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 40) begin
         @(posedge clock); #1;
         cyc++;
      end
   endtask

   initial begin
      int  cyc;
      bit  seen;
      vt[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vt[1]  = '{MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
      vt[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vt[3]  = '{DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
      vt[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vt[5]  = '{MULTU, 32'h12345678, 32'h100,      32'h00000012, 32'h34567800};
      vt[6]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vt[7]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vt[8]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vt[9]  = '{DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
      vt[10] = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
      vt[11] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vt[12] = '{DIVU,  32'd7,        32'd9,        32'd7,        32'd0};
      reset = 1'b1;
      bus.start = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0;
      bus.hi_write = 1'b0; bus.lo_write = 1'b0; bus.write_data = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      reset = 1'b0;
      // MTHI/MTLO together, then MTHI alone
      @(negedge clock);
      bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.write_data = 32'h12345678;
      @(posedge clock); #1;
      bus.lo_write = 1'b0; bus.write_data = 32'hA5A5A5A5;
      @(posedge clock); #1;
      bus.hi_write = 1'b0;
      chk("mthi", bus.hi, 32'hA5A5A5A5);
      chk("mtlo", bus.lo, 32'h12345678);
      // start wins over a simultaneous hi_write
      @(negedge clock);
      bus.start = 1'b1; bus.op = MULTU; bus.operand_a = 32'd2; bus.operand_b = 32'd3;
      bus.hi_write = 1'b1; bus.write_data = 32'hFFFF0000;
      @(posedge clock); #1;
      bus.start = 1'b0; bus.hi_write = 1'b0;
      chk("sw_busy", 32'(bus.busy), 32'd1);
      chk("sw_hi_held", bus.hi, 32'hA5A5A5A5);
      wait_done(cyc);
      chk("sw_lat", 32'(cyc), 32'd33);
      chk("sw_hi", bus.hi, 32'd0);
      chk("sw_lo", bus.lo, 32'd6);
      for (int i = 0; i < 13; i++) begin
         start_op(vt[i].op, vt[i].a, vt[i].b);
         chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd1);
         wait_done(cyc);
         chk($sformatf("v%0d_lat", i), 32'(cyc), 32'd33);
         chk($sformatf("v%0d_done_busy", i), 32'(bus.busy), 32'd0);
         chk($sformatf("v%0d_hi", i), bus.hi, vt[i].hi);
         chk($sformatf("v%0d_lo", i), bus.lo, vt[i].lo);
         @(posedge clock); #1;
         chk($sformatf("v%0d_done_1cyc", i), 32'(bus.done), 32'd0);
      end
      // start during the done cycle is accepted
      start_op(MULTU, 32'd7, 32'd8);
      wait_done(cyc);
      bus.start = 1'b1; bus.op = DIVU; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
      @(posedge clock); #1;
      bus.start = 1'b0;
      chk("bb_busy", 32'(bus.busy), 32'd1);
      chk("bb_hi_hold", bus.hi, 32'd0);
      chk("bb_lo_hold", bus.lo, 32'd56);
      wait_done(cyc);
      chk("bb_lat", 32'(cyc), 32'd33);
      chk("bb_hi", bus.hi, 32'd2);
      chk("bb_lo", bus.lo, 32'd14);
      // start and hi_write while busy are ignored
      start_op(MULTU, 32'd5, 32'd6);
      repeat (2) @(posedge clock);
      #1;
      bus.start = 1'b1; bus.op = MULTU; bus.operand_a = 32'd9; bus.operand_b = 32'd9;
      @(posedge clock); #1;
      bus.start = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      bus.hi_write = 1'b1; bus.write_data = 32'hDEAD;
      @(posedge clock); #1;
      bus.hi_write = 1'b0;
      chk("ig_hi_write", bus.hi, 32'd2);
      wait_done(cyc);
      chk("ig_done", 32'(bus.done), 32'd1);
      chk("ig_hi", bus.hi, 32'd0);
      chk("ig_lo", bus.lo, 32'd30);
      // reset mid-operation aborts with no done
      start_op(MULTU, 32'd3, 32'd4);
      repeat (8) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("ab_busy", 32'(bus.busy), 32'd0);
      chk("ab_hi", bus.hi, 32'd0);
      chk("ab_lo", bus.lo, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clock); #1;
         if (bus.done === 1'b1) seen = 1'b1;
      end
      chk("ab_no_done", 32'(seen), 32'd0);
      chk("ab_lo_after", bus.lo, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 Ports SHALL be exactly as listed in REQ-003 to REQ-013.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new operation; sampled on the rising edge.
REQ-006 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 operand_a  input  32  rs value; multiplicand or dividend.
REQ-008 operand_b  input  32  rt value; multiplier or divisor.
REQ-009 hi_write  input  1  MTHI request: load hi from write_data.
REQ-010 lo_write  input  1  MTLO request: load lo from write_data.
REQ-011 write_data  input  32  data for hi_write and lo_write.
REQ-012 busy, done  output  1 each  busy: operation in progress; done: one-cycle completion pulse.
REQ-013 hi, lo  output  32 each  HI/LO architectural registers, readable at all times.

Function
REQ-014 States SHALL be IDLE, CALC and FIX.
- IDLE to CALC: on start=1.
- CALC to FIX: after 32 iteration cycles.
- FIX to IDLE: unconditionally.
REQ-015 On start accepted in IDLE, the block SHALL latch op, operand_a and operand_b, clear the 5-bit iteration counter, and assert busy from the next cycle.
REQ-016 Operand inputs SHALL be don't-care after the accepting edge; the latched copies are used.
REQ-017 CALC SHALL run one radix-2 step per cycle on operand magnitudes.
- Multiply: shift-add.
- Divide: restoring shift-subtract.
- Counter runs 0..31; wrap from 31 moves to FIX.
REQ-018 FIX SHALL apply sign correction and write hi/lo.
- Signed ops: sign-correct results on the operand signs.
- Unsigned ops: no correction.
REQ-019 Latency: a start accepted at edge k SHALL make hi/lo valid after edge k+33.
- done=1 for exactly the cycle following edge k+33.
- busy=1 after edges k..k+32, and 0 when done=1.
REQ-020 MULT/MULTU SHALL produce the full 64-bit product: hi = bits [63:32], lo = bits [31:0].
REQ-021 DIV/DIVU SHALL write the quotient to lo and the remainder to hi.
- Signed quotient truncates toward zero.
- Remainder takes the sign of the dividend.
REQ-022 Divide by zero SHALL still take 33 cycles and produce hi = dividend, lo = 32'hFFFFFFFF.
REQ-023 Signed DIV of 32'h80000000 by 32'hFFFFFFFF SHALL produce lo = 32'h80000000, hi = 0.
REQ-024 start while busy=1 (CALC or FIX) SHALL be ignored, with no queuing.
REQ-025 A start during the done cycle SHALL be accepted, since the state is IDLE.
REQ-026 hi_write/lo_write in IDLE SHALL update the respective register at that edge; both may assert together.
REQ-027 hi_write/lo_write while busy=1 SHALL be ignored.
REQ-028 Simultaneous start and hi_write/lo_write in IDLE: start SHALL win and the write is dropped.
REQ-029 hi and lo SHALL hold their previous values throughout CALC and change only in FIX or via REQ-026.

Reset
REQ-030 reset=1 at a rising edge SHALL, in any state, force:
- state = IDLE, iteration counter = 0;
- busy = 0, done = 0;
- hi = 32'h0, lo = 32'h0.
REQ-031 Reset mid-operation SHALL abort the operation with no hi/lo update, and the aborted operation SHALL NOT produce done.
REQ-032 Reset SHALL take priority over start, hi_write and lo_write in the same cycle.

Verification
REQ-033 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> after 33 cycles hi=32'hFFFFFFFE, lo=32'h00000001; done high for exactly 1 cycle.
REQ-034 MULT a=-3 (32'hFFFFFFFD), b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-035 DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
REQ-036 DIVU a=100, b=0 -> hi=32'd100, lo=32'hFFFFFFFF.
REQ-037 DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-038 Combined control scenario -> required responses:
- Start MULTU 5*6, then start with different operands at cycle 3 -> ignored; result hi=0, lo=30.
- hi_write with 32'hDEAD at cycle 10 -> ignored.
- New MULTU run with reset asserted at cycle 10 -> busy=0, hi=lo=0, no done pulse.
